sipo_deser_align: RTL
=====================

Name: sipo_deser_align

Overview:
- Parametrised serial-in/parallel-out deserialiser; successor to the fixed 10-bit SIPO used in the CMOS synthesis cases.
- Shifts one bit per enabled clock, LSB first, into a WIDTH-bit word.
- Optional sync-word hunt sets the word boundary, and a miss counter detects loss of lock.
- Output uses a VALID/READY hold register with a sticky overrun flag. Sits between the serial link receiver and the word-level consumer.

Parameters:
- WIDTH, 10: word width in bits; legal range 2..32.
- ALIGN_MODE, 0: 0 = free-running boundary (counter from reset); 1 = hunt for SYNC_WORD before emitting words.
- SYNC_WORD, 10'h17C: alignment pattern, WIDTH bits, compared against the full shift window.
- MAX_MISS, 4: number of consecutive non-sync words at boundaries before LOCKED returns to HUNT; 0 disables loss detection. Ignored when ALIGN_MODE=0.

Ports:
- CLK_IN  in  1  clock
- RESET_IN  in  1  reset, asynchronous, active-high
- EN_IN  in  1  bit-enable; shift/count only when 1
- SERIAL_IN  in  1  serial data, LSB of word first
- READY_IN  in  1  consumer accepts current word when VALID_OUT=1
- CLR_ERR_IN  in  1  synchronous clear of OVERRUN_OUT
- PARALLEL_OUT  out  WIDTH  last completed word
- VALID_OUT  out  1  PARALLEL_OUT holds an unaccepted word
- SYNC_FLAG_OUT  out  1  PARALLEL_OUT equals SYNC_WORD (qualified by VALID_OUT)
- LOCKED_OUT  out  1  word boundary established
- OVERRUN_OUT  out  1  sticky: a word was overwritten before acceptance

Behaviour:
- Reset (async) clears shift_reg, ctr, miss counter, PARALLEL_OUT, VALID_OUT, SYNC_FLAG_OUT and OVERRUN_OUT.
- After reset, state = LOCKED if ALIGN_MODE=0 and HUNT if ALIGN_MODE=1. LOCKED_OUT = (state==LOCKED).
- next = {SERIAL_IN, shift_reg[WIDTH-1:1]}. On an EN_IN=1 edge, shift_reg <= next. With EN_IN=0, shift_reg, ctr and miss are unchanged.
- ctr is clog2(WIDTH) bits, counts 0..WIDTH-1 on EN_IN edges and wraps to 0.
- HUNT:
  - ctr is held at 0 and no words are emitted.
  - On an EN_IN edge with next==SYNC_WORD: state <= LOCKED, ctr <= 0, miss <= 0.
  - The sync word that achieved lock is not emitted.
- LOCKED, boundary = EN_IN && ctr==WIDTH-1. At a boundary:
  - PARALLEL_OUT <= next; VALID_OUT <= 1; SYNC_FLAG_OUT <= (next==SYNC_WORD).
  - Latency: the word is visible the cycle after the edge that samples its last bit.
- Miss logic applies only when ALIGN_MODE=1 and MAX_MISS>0, evaluated at a boundary:
  - match → miss <= 0.
  - otherwise miss <= miss+1; if miss+1==MAX_MISS, then state <= HUNT, ctr <= 0, miss <= 0.
  - The mismatching word is still emitted.
- Handshake:
  - Accept = VALID_OUT && READY_IN. A word is accepted on that edge; VALID_OUT <= 0 unless a new boundary occurs on the same edge.
  - Boundary with VALID_OUT=1 and READY_IN=1 → new word loaded, VALID_OUT stays 1, no overrun.
  - Boundary with VALID_OUT=1 and READY_IN=0 → new word overwrites, OVERRUN_OUT <= 1.
  - READY_IN while VALID_OUT=0 is ignored.
- OVERRUN_OUT clears only on CLR_ERR_IN=1 or reset. If CLR_ERR_IN and a new overrun occur on the same edge, the set wins.
- Entering HUNT does not clear VALID_OUT; a pending word stays available until accepted.
- Reset mid-word discards the partial word; bit counting restarts at 0 on the first EN_IN edge after reset release.

Decomposition:
- Shared include holds the state encoding (HUNT=1'b0, LOCKED=1'b1), the clog2 function and WIDTH/MAX_MISS legality checks.
- One natural sub-module: sipo_out_hold, the VALID/READY hold register with overrun detection.
- Shift register, counter and FSM stay in the top module.

Test Plan:
- ALIGN_MODE=0, EN_IN=1: shift 0x2A5 LSB-first from reset → VALID_OUT=1 on the cycle after the 10th edge, PARALLEL_OUT=0x2A5, SYNC_FLAG_OUT=0.
- ALIGN_MODE=1: 7 random bits, then 0x17C, then 0x155 → LOCKED_OUT=1 after the last sync bit, no VALID for the sync word, PARALLEL_OUT=0x155 ten enabled cycles later.
- MAX_MISS=3, locked: send words 0x001, 0x002, 0x003 → all three emitted, LOCKED_OUT=0 after the third boundary; an interleaved 0x17C resets the miss count.
- READY_IN=0 across words 0x0AA then 0x155 → PARALLEL_OUT=0x155, OVERRUN_OUT=1; CLR_ERR_IN pulse → OVERRUN_OUT=0; READY_IN=1 at the boundary → no overrun.
- EN_IN=1 every other cycle, word 0x2A5 → identical result after 20 clocks; EN_IN=0 cycles leave ctr and shift_reg frozen.
- RESET_IN asserted after 5 bits, then 0x133 sent → PARALLEL_OUT=0x133; all outputs 0 during reset.

Source files
------------

// File: rtl/sipo_deser_align_pkg.sv
// Shared types and elaboration helpers for the SIPO deserialiser with sync-word alignment.
package sipo_deser_align_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Minimum of one bit so that degenerate ranges still produce a legal vector.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit width_legal(input int unsigned w);
        return (w >= 2) && (w <= 32);
    endfunction

    function automatic bit max_miss_legal(input int unsigned m);
        return m <= 255;
    endfunction

endpackage

// File: rtl/sipo_deser_align_if.sv
// Serial-in / word-out signal bundle between link receiver, deserialiser and consumer.
interface sipo_deser_align_if #(
    parameter int unsigned WIDTH = 10
);
    logic             EN_IN;
    logic             SERIAL_IN;
    logic             READY_IN;
    logic             CLR_ERR_IN;
    logic [WIDTH-1:0] PARALLEL_OUT;
    logic             VALID_OUT;
    logic             SYNC_FLAG_OUT;
    logic             LOCKED_OUT;
    logic             OVERRUN_OUT;

    modport master (
        output EN_IN, SERIAL_IN, READY_IN, CLR_ERR_IN,
        input  PARALLEL_OUT, VALID_OUT, SYNC_FLAG_OUT, LOCKED_OUT, OVERRUN_OUT
    );

    modport slave (
        input  EN_IN, SERIAL_IN, READY_IN, CLR_ERR_IN,
        output PARALLEL_OUT, VALID_OUT, SYNC_FLAG_OUT, LOCKED_OUT, OVERRUN_OUT
    );
endinterface

// File: rtl/sipo_out_hold.sv
// VALID/READY output hold register; flags a sticky overrun when an unaccepted word is replaced.
module sipo_out_hold #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic             load_in,
    input  logic [WIDTH-1:0] word_in,
    input  logic             sync_in,
    input  logic             ready_in,
    input  logic             clr_err_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             sync_out,
    output logic             overrun_out
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic             overrun_q, overrun_d;

    // A new word on the accept edge replaces the old one cleanly; set of overrun beats clear.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        sync_d    = sync_q;
        overrun_d = overrun_q;
        if (clr_err_in) overrun_d = 1'b0;
        if (load_in) begin
            data_d  = word_in;
            valid_d = 1'b1;
            sync_d  = sync_in;
            if (valid_q && !ready_in) overrun_d = 1'b1;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign sync_out    = sync_q;
    assign overrun_out = overrun_q;
endmodule

// File: rtl/sipo_deser_align.sv
// Parametrised LSB-first deserialiser with optional sync-word hunt and loss-of-lock detection.
module sipo_deser_align
    import sipo_deser_align_pkg::*;
#(
    parameter int unsigned      WIDTH      = 10,
    parameter int unsigned      ALIGN_MODE = 0,
    parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(10'h17C),
    parameter int unsigned      MAX_MISS   = 4
) (
    input logic               CLK_IN,
    input logic               RESET_IN,
    sipo_deser_align_if.slave bus
);
    localparam int unsigned        CTR_W      = clog2(WIDTH);
    localparam int unsigned        MISS_W     = clog2(MAX_MISS + 1);
    localparam logic [CTR_W-1:0]   CTR_LAST   = CTR_W'(WIDTH - 1);
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISS);
    localparam bit                 MISS_EN    = (ALIGN_MODE == 1) && (MAX_MISS > 0);
    localparam state_e             RST_STATE  = (ALIGN_MODE == 0) ? LOCKED : HUNT;

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("sipo_deser_align: WIDTH must be 2..32");
        end
        if (ALIGN_MODE > 1) begin : g_bad_mode
            $error("sipo_deser_align: ALIGN_MODE must be 0 or 1");
        end
        if (!max_miss_legal(MAX_MISS)) begin : g_bad_miss
            $error("sipo_deser_align: MAX_MISS out of range");
        end
    endgenerate

    // The oldest bit is dropped on every shift, so only the upper WIDTH-1 bits are stored.
    logic [WIDTH-2:0]  shift_q, shift_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  word_c;
    logic [MISS_W-1:0] miss_inc_c;
    logic              is_sync_c;
    logic              boundary_c;

    always_comb begin
        word_c     = {bus.SERIAL_IN, shift_q};
        is_sync_c  = (word_c == SYNC_WORD);
        boundary_c = bus.EN_IN && (state_q == LOCKED) && (ctr_q == CTR_LAST);
        miss_inc_c = miss_q + MISS_W'(1);
        shift_d    = shift_q;
        ctr_d      = ctr_q;
        miss_d     = miss_q;
        state_d    = state_q;
        if (bus.EN_IN) begin
            shift_d = word_c[WIDTH-1:1];
            if (state_q == HUNT) begin
                ctr_d = '0;
                if (is_sync_c) begin
                    state_d = LOCKED;
                    miss_d  = '0;
                end
            end else begin
                ctr_d = boundary_c ? '0 : ctr_q + CTR_W'(1);
                // Loss of lock after MAX_MISS consecutive non-sync words; the miss word is still emitted.
                if (MISS_EN && boundary_c) begin
                    if (is_sync_c) begin
                        miss_d = '0;
                    end else if (miss_inc_c == MISS_LIMIT) begin
                        state_d = HUNT;
                        ctr_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_inc_c;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            shift_q <= '0;
            ctr_q   <= '0;
            miss_q  <= '0;
            state_q <= RST_STATE;
        end else begin
            shift_q <= shift_d;
            ctr_q   <= ctr_d;
            miss_q  <= miss_d;
            state_q <= state_d;
        end
    end

    sipo_out_hold #(
        .WIDTH(WIDTH)
    ) u_out_hold (
        .CLK_IN      (CLK_IN),
        .RESET_IN    (RESET_IN),
        .load_in     (boundary_c),
        .word_in     (word_c),
        .sync_in     (is_sync_c),
        .ready_in    (bus.READY_IN),
        .clr_err_in  (bus.CLR_ERR_IN),
        .data_out    (bus.PARALLEL_OUT),
        .valid_out   (bus.VALID_OUT),
        .sync_out    (bus.SYNC_FLAG_OUT),
        .overrun_out (bus.OVERRUN_OUT)
    );

    assign bus.LOCKED_OUT = (state_q == LOCKED);
endmodule
